// File: rtl/dbg_loader_pkg.sv
// Shared types and helpers for the debug program loader.
package dbg_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned ADDR_STRIDE = 4;
    localparam int unsigned MAX_ADDR_W  = 128;

    // Instruction addresses are word aligned; low bits are dropped.
    function automatic logic [MAX_ADDR_W-1:0] align_addr(input logic [MAX_ADDR_W-1:0] addr);
        return addr & ~MAX_ADDR_W'(ADDR_STRIDE - 1);
    endfunction

endpackage

// File: rtl/dbg_word_assembler.sv
// Collects little-endian bytes into one instruction word.
module dbg_word_assembler
    import dbg_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_in,
    output logic [8*INSTR_BYTES-1:0] word,
    output logic                     word_done
);

    localparam int unsigned CNT_W = $clog2(INSTR_BYTES);

    logic [CNT_W-1:0]         byte_cnt;
    logic [8*INSTR_BYTES-1:0] lanes;

    // word already includes the byte being accepted this cycle
    always_comb begin
        word = lanes;
        word[8*byte_cnt +: 8] = byte_in;
    end

    assign word_done = byte_valid && (byte_cnt == CNT_W'(INSTR_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (byte_valid) begin
            lanes    <= word;
            byte_cnt <= word_done ? '0 : byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dbg_program_loader.sv
// Streams bytes into cpuCore instruction memory via the debug write port,
// holding the core in reset until the whole program is loaded.
module dbg_program_loader
    import dbg_loader_pkg::*;
#(
    parameter int unsigned XLEN               = 64,
    parameter int unsigned INSTRUCTION_LENGTH = XLEN / 2,
    parameter int unsigned LEN_W              = 16,
    parameter int unsigned SETUP_CYCLES       = 2,
    parameter int unsigned HOLD_CYCLES        = 1,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [XLEN-1:0]               base_addr,
    input  logic [LEN_W-1:0]              load_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_byte,
    output logic                          dbg_wr_en,
    output logic [XLEN-1:0]               dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
    output logic                          core_rst,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    loader_state_t                 state_q, state_d;
    logic [31:0]                   timer_q, timer_d;
    logic [XLEN-1:0]               addr_q, addr_d;
    logic [INSTRUCTION_LENGTH-1:0] instr_q, instr_d;
    logic [LEN_W-1:0]              cnt_q, cnt_d;
    logic [LEN_W-1:0]              len_q, len_d;
    logic [LEN_W-1:0]              cnt_inc;
    logic                          handshake;
    logic                          asm_clear;
    logic                          word_done;
    logic [8*INSTR_BYTES-1:0]      asm_word;

    assign handshake = in_valid && (state_q == S_COLLECT);
    assign cnt_inc   = cnt_q + LEN_W'(1);

    dbg_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (handshake),
        .byte_in    (in_byte),
        .word       (asm_word),
        .word_done  (word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        asm_clear = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    addr_d    = XLEN'(align_addr(MAX_ADDR_W'(base_addr)));
                    cnt_d     = '0;
                    len_d     = load_len;
                    timer_d   = '0;
                    asm_clear = 1'b1;
                    state_d   = (load_len == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (handshake) begin
                    timer_d = '0;
                    if (word_done) begin
                        instr_d = INSTRUCTION_LENGTH'(asm_word);
                        state_d = S_SETUP;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    // timer counts idle cycles since the last accepted byte
                    if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        timer_d   = '0;
                        asm_clear = 1'b1;
                        state_d   = S_ERROR;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
            end
            S_SETUP: begin
                if (timer_q == 32'(SETUP_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_WRITE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_WRITE: begin
                timer_d = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (timer_q == 32'(HOLD_CYCLES - 1)) begin
                    timer_d = '0;
                    cnt_d   = cnt_inc;
                    addr_d  = addr_q + XLEN'(ADDR_STRIDE);
                    state_d = (cnt_inc == len_q) ? S_DONE : S_COLLECT;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_COLLECT);
    assign dbg_wr_en = (state_q == S_WRITE);
    assign busy      = (state_q == S_COLLECT) || (state_q == S_SETUP) ||
                       (state_q == S_WRITE)   || (state_q == S_HOLD);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERROR);
    assign core_rst  = (state_q != S_DONE);
    assign dbg_addr  = addr_q;
    assign dbg_instr = instr_q;

endmodule

// File: tb/tb_dbg_program_loader.sv
// Directed bench for dbg_program_loader with an expected-write scoreboard.
module tb_dbg_program_loader;

    typedef struct packed {
        logic [63:0] a;
        logic [31:0] i;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] base_addr = '0;
    logic [15:0] load_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_ready, dbg_wr_en, core_rst, busy, done, err;
    logic [63:0] dbg_addr;
    logic [31:0] dbg_instr;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned last_hs_cyc = 0;
    wr_t         exp_q[$];
    wr_t         e;
    logic [95:0] cur, h1, h2;
    bit          hold_pend = 0;
    bit          rel_pend = 0;

    dbg_program_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .load_len  (load_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .dbg_wr_en (dbg_wr_en),
        .dbg_addr  (dbg_addr),
        .dbg_instr (dbg_instr),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: pops expected writes and checks setup/hold stability and release timing.
    always @(negedge clk) begin
        cur = {dbg_addr, dbg_instr};
        if (rel_pend) begin
            check("release_core_rst", core_rst, 0);
            check("release_done", done, 1);
            rel_pend = 0;
        end
        if (hold_pend) begin
            check("hold_wr_en", dbg_wr_en, 0);
            check("hold_stable", cur == h1, 1);
            check("hold_core_rst", core_rst, 1);
            hold_pend = 0;
            if (exp_q.size() == 0) rel_pend = 1;
        end
        if (!rst && dbg_wr_en) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr_en", dbg_wr_en, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", dbg_addr, e.a);
                check("wr_instr", dbg_instr, 64'(e.i));
                check("setup_stable", (h1 == cur) && (h2 == cur), 1);
                check("wr_core_rst", core_rst, 1);
                hold_pend = 1;
            end
        end
        h2 = h1;
        h1 = cur;
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("hs_budget", in_ready, 1);
        @(posedge clk);
        #1;
        last_hs_cyc = cyc;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int j = 0; j < 4; j++) begin
            send_byte(w[8*j +: 8]);
            if (gap > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [63:0] addr, input logic [15:0] len);
        @(negedge clk);
        start     = 1'b1;
        base_addr = addr;
        load_len  = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && !err && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(tag, done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t2w [9];
        int k;
        t2w = '{32'h00100093, 32'h0050A113, 32'h0050B193, 32'h0070F213, 32'h0080E293,
                32'h0090C313, 32'h00209393, 32'h0020D393, 32'h4020D413};

        // reset state
        #12;
        check("rst_wr_en", dbg_wr_en, 0);
        check("rst_addr", dbg_addr, 0);
        check("rst_instr", dbg_instr, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // single instruction
        exp_q.push_back('{a: 64'h0, i: 32'h00100093});
        do_start(64'h0, 16'd1);
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 1);
        send_word(32'h00100093, 0);
        go_idle();
        wait_done("t1_done");
        check("t1_core_rst", core_rst, 0);
        check("t1_err", err, 0);
        check("t1_drain", exp_q.size(), 0);

        // nine instructions
        for (int i = 0; i < 9; i++) exp_q.push_back('{a: 64'(4 * i), i: t2w[i]});
        do_start(64'h0, 16'd9);
        check("t2_core_rst", core_rst, 1);
        check("t2_done_clr", done, 0);
        for (int i = 0; i < 9; i++) send_word(t2w[i], 0);
        go_idle();
        wait_done("t2_done");
        check("t2_drain", exp_q.size(), 0);

        // back-pressure gaps, unaligned base
        exp_q.push_back('{a: 64'h100, i: 32'hDEADBEEF});
        do_start(64'h103, 16'd1);
        check("t3_addr", dbg_addr, 64'h100);
        send_word(32'hDEADBEEF, 2);
        go_idle();
        wait_done("t3_done");
        check("t3_drain", exp_q.size(), 0);

        // timeout after two bytes
        do_start(64'h200, 16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        go_idle();
        k = 0;
        while (!err && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t4_err", err, 1);
        check("t4_latency", 64'(cyc - last_hs_cyc), 16);
        check("t4_core_rst", core_rst, 1);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);

        // reload from error
        exp_q.push_back('{a: 64'h200, i: 32'hCAFEF00D});
        do_start(64'h200, 16'd1);
        check("t4_err_clr", err, 0);
        check("t4_reload_busy", busy, 1);
        send_word(32'hCAFEF00D, 0);
        go_idle();
        wait_done("t4_reload_done");
        check("t4_drain", exp_q.size(), 0);

        // zero-length load
        do_start(64'h300, 16'd0);
        check("t5_zero_done", done, 1);
        check("t5_zero_core_rst", core_rst, 0);
        check("t5_zero_busy", busy, 0);
        check("t5_zero_in_ready", in_ready, 0);

        // start during SETUP is ignored
        exp_q.push_back('{a: 64'h40, i: 32'h11223344});
        exp_q.push_back('{a: 64'h44, i: 32'h55667788});
        do_start(64'h40, 16'd2);
        send_word(32'h11223344, 0);
        do_start(64'h800, 16'd5);
        check("t5_ignored_busy", busy, 1);
        send_word(32'h55667788, 0);
        go_idle();
        wait_done("t5_done");
        check("t5_drain", exp_q.size(), 0);

        // reset during WRITE
        do_start(64'h300, 16'd1);
        send_word(32'h12345678, 0);
        in_valid = 1'b0;
        k = 0;
        while (!dbg_wr_en && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t6_reach_write", dbg_wr_en, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_wr_en_drop", dbg_wr_en, 0);
        check("t6_busy_drop", busy, 0);
        check("t6_done_low", done, 0);
        check("t6_core_rst_async", core_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_in_ready", in_ready, 0);
        check("t6_busy", busy, 0);
        check("t6_core_rst", core_rst, 1);
        check("t6_addr", dbg_addr, 0);
        check("t6_instr", dbg_instr, 0);
        check("t6_err", err, 0);
        check("t6_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dbg_program_loader.md
Name: dbg_program_loader

Overview:
Sequences the cpuCore debug instruction-write port (dbg_wr_en/dbg_addr/dbg_instr) from a byte stream, such as a UART receiver. It assembles little-endian 32-bit instructions and drives each write with a fixed setup/pulse/hold timing. It holds the core in reset for the whole load and releases it only when the load completes. It sits between the host link and cpuCore and replaces hand-driven debug writes.

Parameters:
XLEN, 64, address width of dbg_addr
INSTRUCTION_LENGTH, XLEN/2, instruction width (32)
LEN_W, 16, width of load_len (instruction count)
SETUP_CYCLES, 2, cycles addr/instr are stable before the write pulse (>=1)
HOLD_CYCLES, 1, cycles addr/instr are held after the write pulse (>=1)
TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes in COLLECT; 0 disables the timeout

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load
base_addr  in  XLEN  first write address, sampled at start; bits [1:0] forced to 0
load_len  in  LEN_W  number of instructions, sampled at start
in_valid  in  1  byte stream valid
in_ready  out  1  byte stream ready
in_byte  in  8  byte stream data
dbg_wr_en  out  1  instruction-memory write strobe to cpuCore
dbg_addr  out  XLEN  instruction-memory write address
dbg_instr  out  INSTRUCTION_LENGTH  instruction-memory write data
core_rst  out  1  reset to cpuCore; high while not released
busy  out  1  load in progress
done  out  1  last load completed; sticky until next start or rst
err  out  1  last load timed out; sticky until next start or rst

Behaviour:
- Reset (asynchronous):
  - Outputs: dbg_wr_en=0, dbg_addr=0, dbg_instr=0, core_rst=1, busy=0, done=0, err=0, in_ready=0.
  - State: IDLE; all counters cleared.
- States: IDLE, COLLECT, SETUP, WRITE, HOLD, DONE, ERROR. All outputs are decoded from registered state or registered directly.
- Signal decodes:
  - in_ready=1 only in COLLECT.
  - dbg_wr_en=1 only in WRITE, for exactly one cycle per instruction.
  - busy=1 in COLLECT, SETUP, WRITE and HOLD.
- start is accepted in IDLE, DONE and ERROR, and ignored while busy. On acceptance:
  - core_rst=1, done=0, err=0.
  - dbg_addr=base_addr & ~3; instr count=0; byte count=0.
  - Next state is COLLECT, or DONE if load_len==0 (no write is issued).
- COLLECT:
  - Each handshake (in_valid & in_ready) stores in_byte into byte lane byte_cnt; the first byte goes to [7:0].
  - On the 4th handshake, dbg_instr is loaded with the assembled word and the state goes to SETUP.
  - The timeout counter clears on every handshake. If it reaches TIMEOUT_CYCLES, go to ERROR.
- SETUP: stay SETUP_CYCLES cycles, then go to WRITE. dbg_addr/dbg_instr are stable throughout.
- WRITE: one cycle, then go to HOLD.
- HOLD: stay HOLD_CYCLES cycles with addr/instr unchanged. On exit:
  - instr count += 1 and dbg_addr += 4 (mod 2^XLEN; wrap is allowed, no error).
  - If the count equals load_len, go to DONE; otherwise go to COLLECT.
- DONE: core_rst=0, done=1. Release takes effect the cycle after the final HOLD cycle.
- ERROR: err=1, core_rst stays 1, and no further writes are issued. The partial byte is discarded.
- Throughput with defaults and continuous in_valid: 8 cycles per instruction (4 collect + 2 setup + 1 write + 1 hold).
- Width rules:
  - The count comparison is exact against the sampled load_len, so up to 2^LEN_W-1 instructions.
  - Bytes beyond the 4th are never accepted within a word.
- Reset mid-operation: everything returns to reset values immediately, and core_rst reasserts asynchronously. A write in progress is abandoned; dbg_wr_en drops with reset.
- Simultaneous start and rst: rst wins.

Decomposition:
- dbg_loader_pkg holds:
  - the loader_state_t enum;
  - INSTR_BYTES=4 and ADDR_STRIDE=4;
  - a function to align base_addr.
- One sub-module, dbg_word_assembler, holds the byte-lane shift/merge, byte count and word-complete flag. The FSM, timing counters and address/count tracking stay in dbg_program_loader.

Test Plan:
1. Single instruction, continuous bytes:
   - Stimulus: start with base_addr=0, load_len=1; bytes 93 00 10 00.
   - Response: one dbg_wr_en pulse with dbg_addr=0 and dbg_instr=32'h00100093, stable 2 cycles before and 1 cycle after the pulse; then done=1 and core_rst=0.
2. Nine instructions (ADDI, SLTI, SLTIU, ANDI, ORI, XORI, SLLI, SRLI, SRAI):
   - Stimulus: base_addr=0.
   - Response: nine pulses at addresses 0, 4, …, 32 with the matching words, e.g. 32'h4020D413 at 32; core_rst stays high until after the 9th HOLD.
3. Back-pressure gaps:
   - Stimulus: in_valid toggling 1-0-0-1 between bytes.
   - Response: bytes assemble correctly and there is no spurious wr_en; base_addr=32'h103 is written to 32'h100.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16; send 2 bytes, then stall.
   - Response: err=1 exactly 16 cycles after the last byte, no write issued, core_rst=1. A new start clears err and the reload succeeds.
5. Edge controls:
   - Stimulus: load_len=0, then a start pulse during SETUP of a 2-instruction load.
   - Response: first case gives done=1 and core_rst=0 with no writes; second case shows the start is ignored and both instructions are written.
6. Reset in WRITE:
   - Stimulus: assert rst mid-cycle during WRITE.
   - Response: dbg_wr_en, busy and done drop and core_rst rises asynchronously. After release, state is IDLE and in_ready=0.
